pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Parametrised PC/next-PC unit for the RV32I core. Replaces the fixed pc_src mux.
//  Adds an instruction-fetch valid/ready handshake and a registered redirect.
//  Resolves all six conditional branches, jal and jalr.
//  Detects misaligned targets, with a trap or halt policy, and keeps fetch/redirect counters.
//  Sits between instruction memory (fetch side) and the execute stage (resolution side).
// PARAMETERS
//  XLEN          32        datapath/address width
//  RESET_VECTOR  'h0       PC value loaded by rst
//  TRAP_VECTOR   'h100     PC loaded on misaligned-target trap
//  IALIGN        4         required target alignment in bytes (4, or 2 for RVC)
//  HALT_ON_TRAP  0         1: enter HALT on trap instead of jumping to TRAP_VECTOR
//  CNT_W         32        width of performance counters
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  fetch_valid  out  1       pc holds a valid fetch address
//  fetch_ready  in   1       imem accepts fetch at pc this cycle
//  pc           out  XLEN    current fetch address
//  exec_valid   in   1       execute stage holds a valid instruction to resolve
//  exec_pc      in   XLEN    PC of the executing instruction
//  pc_src       in   2       00 seq, 01 jal, 10 jalr, 11 branch
//  func3        in   3       branch type: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
//  rs1_val      in   XLEN    register operand 1
//  rs2_val      in   XLEN    register operand 2
//  imm          in   XLEN    sign-extended immediate
//  link_addr    out  XLEN    exec_pc+4, written to rd for jal/jalr (comb)
//  redirect     out  1       comb: kill younger instructions, PC changes next cycle
//  taken        out  1       comb: branch condition true (pc_src=11 only)
//  trap         out  1       registered 1-cycle pulse on misaligned target
//  trap_pc      out  XLEN    exec_pc of last trapping instruction
//  halted       out  1       state==HALT
//  fetch_cnt    out  CNT_W   accepted fetches (fetch_valid&fetch_ready)
//  redir_cnt    out  CNT_W   redirects taken, including traps
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, state=BOOT, trap=0, trap_pc=0, counters=0, fetch_valid=0.
//  FSM: BOOT -(1 cycle)-> RUN; RUN -(trap & HALT_ON_TRAP)-> HALT; HALT exits only via rst.
//  fetch_valid=1 only in RUN. Exec inputs are ignored (redirect=0) in BOOT/HALT.
//  Targets (mod 2^XLEN, wrap):
//   - jal/branch: exec_pc+imm
//   - jalr: (rs1_val+imm) & ~1
//  Conditions: signed compare for blt/bge, unsigned for bltu/bgeu.
//   func3 010/011 -> taken=0.
//  redirect = RUN & exec_valid & (pc_src==01 | pc_src==10 | (pc_src==11 & taken)).
//  misalign = redirect & (target % IALIGN != 0).
//  Next pc, priority order:
//   1. rst
//   2. misalign -> TRAP_VECTOR (or hold pc, enter HALT)
//   3. redirect -> target
//   4. fetch_valid & fetch_ready -> pc+IALIGN... pc+4
//   5. hold
//  On misalign: trap=1 next cycle for exactly 1 cycle; trap_pc<=exec_pc.
//  A not-taken branch or pc_src=00 never redirects; pc advances only on accept.
//  Redirect and accept in the same cycle: redirect wins for pc; fetch_cnt still increments.
//  Stall (fetch_ready=0) holds pc and keeps fetch_valid=1.
//  Redirect during stall still updates pc next cycle.
//  Counters wrap at 2^CNT_W. redir_cnt increments once per redirect cycle.
//  rst mid-operation: all state returns to reset values next edge; pending redirect discarded.
// TESTING
//  1. rst 2 cycles, fetch_ready=1 -> BOOT 1 cycle; then pc 0,4,8,C; fetch_cnt=4 after 4 accepts.
//  2. beq rs1=rs2=5, exec_pc=0x20, imm=0x10 -> redirect=taken=1; next pc=0x30; redir_cnt+1.
//  3. blt rs1=0xFFFFFFFF, rs2=1 -> taken=1; bltu with same operands -> taken=0, pc seq.
//  4. jalr rs1=0x103, imm=0 -> target 0x102, misaligned -> pc=0x100, trap pulse, trap_pc=exec_pc.
//     Same stimulus with HALT_ON_TRAP=1 -> halted=1, fetch_valid=0 until rst.
//  5. fetch_ready=0 for 3 cycles, then jal exec_pc=0x40 imm=-8 -> pc holds, then pc=0x38.
//  6. jal redirect same cycle as rst -> pc=RESET_VECTOR, counters=0, no trap.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter / next-PC unit for the RV32I core. Drives fetch addresses to
//   instruction memory through a valid/ready handshake and takes redirects from
//   the execute stage. It resolves all six conditional branches, jal and jalr,
//   traps on misaligned targets (jump to TRAP_VECTOR, or halt), and keeps
//   counters of accepted fetches and redirects.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   fetch_valid_o   pc_o holds a valid fetch address (RUN state only)
//   fetch_ready_i   instruction memory accepts the fetch this cycle
//   pc_o            current fetch address
//   exec_valid_i    execute stage holds an instruction to resolve
//   exec_pc_i       PC of the executing instruction
//   pc_src_i        00 seq, 01 jal, 10 jalr, 11 branch
//   func3_i         branch type (beq/bne/blt/bge/bltu/bgeu)
//   rs1_val_i,
//   rs2_val_i       register operands
//   imm_i           sign-extended immediate
//   link_addr_o     exec_pc_i + 4, the rd value for jal/jalr
//   redirect_o      younger instructions are killed, PC changes next cycle
//   taken_o         branch condition true (branch instructions only)
//   trap_o          one-cycle pulse following a misaligned target
//   trap_pc_o       exec_pc of the last trapping instruction
//   halted_o        unit is in HALT
//   fetch_cnt_o     number of accepted fetches
//   redir_cnt_o     number of redirects, traps included
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 'h0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 'h100,
  parameter int unsigned       IALIGN       = 4,
  parameter bit                HALT_ON_TRAP = 1'b0,
  parameter int unsigned       CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [XLEN-1:0]  pc_o,
  input  logic             exec_valid_i,
  input  logic [XLEN-1:0]  exec_pc_i,
  input  logic [1:0]       pc_src_i,
  input  logic [2:0]       func3_i,
  input  logic [XLEN-1:0]  rs1_val_i,
  input  logic [XLEN-1:0]  rs2_val_i,
  input  logic [XLEN-1:0]  imm_i,
  output logic [XLEN-1:0]  link_addr_o,
  output logic             redirect_o,
  output logic             taken_o,
  output logic             trap_o,
  output logic [XLEN-1:0]  trap_pc_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [1:0] SRC_JAL    = 2'b01;
  localparam logic [1:0] SRC_JALR   = 2'b10;
  localparam logic [1:0] SRC_BRANCH = 2'b11;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             trap_q;
  logic [XLEN-1:0]  trap_pc_q;
  logic [CNT_W-1:0] fetch_cnt_q, redir_cnt_q;

  logic             run;
  logic             cond;
  logic [XLEN-1:0]  target;
  logic             misalign;
  logic             accept;

  assign run = (state_q == RUN);

  // Branch condition; func3 010/011 are not branches and never take.
  always_comb begin
    cond = 1'b0;
    case (func3_i)
      3'b000:  cond = (rs1_val_i == rs2_val_i);
      3'b001:  cond = (rs1_val_i != rs2_val_i);
      3'b100:  cond = ($signed(rs1_val_i) <  $signed(rs2_val_i));
      3'b101:  cond = ($signed(rs1_val_i) >= $signed(rs2_val_i));
      3'b110:  cond = (rs1_val_i <  rs2_val_i);
      3'b111:  cond = (rs1_val_i >= rs2_val_i);
      default: cond = 1'b0;
    endcase
  end

  assign taken_o = (pc_src_i == SRC_BRANCH) && cond;

  // jalr clears bit 0 of its target; jal and branches are PC-relative.
  assign target = (pc_src_i == SRC_JALR) ? ((rs1_val_i + imm_i) & ~XLEN'(1))
                                         : (exec_pc_i + imm_i);

  assign redirect_o = run && exec_valid_i &&
                      ((pc_src_i == SRC_JAL) || (pc_src_i == SRC_JALR) || taken_o);

  // IALIGN is a power of two, so the modulo reduces to a low-bit mask.
  assign misalign = redirect_o && ((target & XLEN'(IALIGN - 1)) != '0);

  assign accept      = fetch_valid_o && fetch_ready_i;
  assign link_addr_o = exec_pc_i + XLEN'(4);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: BOOT lasts one cycle; HALT is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (misalign && HALT_ON_TRAP) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    fetch_valid_o = 1'b0;
    halted_o      = 1'b0;
    case (state_q)
      RUN:     fetch_valid_o = 1'b1;
      HALT:    halted_o      = 1'b1;
      default: ;
    endcase
  end

  // Next PC: a misaligned target traps (or freezes pc when halting), a legal
  // redirect beats a sequential advance, and a stalled fetch holds pc.
  always_comb begin
    pc_d = pc_q;
    if (misalign) begin
      pc_d = HALT_ON_TRAP ? pc_q : TRAP_VECTOR;
    end else if (redirect_o) begin
      pc_d = target;
    end else if (accept) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // Datapath registers: pc, trap pulse/pc and the performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      trap_q      <= 1'b0;
      trap_pc_q   <= '0;
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      trap_q <= misalign;
      if (misalign) begin
        trap_pc_q <= exec_pc_i;
      end
      if (accept) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (redirect_o) begin
        redir_cnt_q <= redir_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_o        = pc_q;
  assign trap_o      = trap_q;
  assign trap_pc_o   = trap_pc_q;
  assign fetch_cnt_o = fetch_cnt_q;
  assign redir_cnt_o = redir_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Drives two pc_fetch_unit instances from the same stimulus: the default
//   trap-to-vector configuration (fully modelled) and a HALT_ON_TRAP=1 copy
//   that is examined in the halt scenario only. Expected values come from a
//   cycle-level reference model written from the architectural rules.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchReady;
  logic        execValid;
  logic [31:0] execPc;
  logic [1:0]  pcSrc;
  logic [2:0]  func3;
  logic [31:0] rs1Val, rs2Val, imm;

  logic        fetchValid, redirect, taken, trap, halted;
  logic [31:0] pc, linkAddr, trapPc, fetchCnt, redirCnt;

  logic        fetchValidH, redirectH, takenH, trapH, haltedH;
  logic [31:0] pcH, linkAddrH, trapPcH, fetchCntH, redirCntH;

  int checks = 0;
  int errors = 0;

  // Reference model state for the trap-to-vector instance.
  bit          mRun;
  logic [31:0] mPc;
  bit          mTrap;
  logic [31:0] mTrapPc;
  logic [31:0] mFetchCnt, mRedirCnt;

  always #5 clk = ~clk;

  pc_fetch_unit #(.HALT_ON_TRAP(1'b0)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid_o(fetchValid), .fetch_ready_i(fetchReady), .pc_o(pc),
    .exec_valid_i(execValid), .exec_pc_i(execPc), .pc_src_i(pcSrc), .func3_i(func3),
    .rs1_val_i(rs1Val), .rs2_val_i(rs2Val), .imm_i(imm),
    .link_addr_o(linkAddr), .redirect_o(redirect), .taken_o(taken),
    .trap_o(trap), .trap_pc_o(trapPc), .halted_o(halted),
    .fetch_cnt_o(fetchCnt), .redir_cnt_o(redirCnt)
  );

  pc_fetch_unit #(.HALT_ON_TRAP(1'b1)) dutHalt (
    .clk(clk), .rst(rst),
    .fetch_valid_o(fetchValidH), .fetch_ready_i(fetchReady), .pc_o(pcH),
    .exec_valid_i(execValid), .exec_pc_i(execPc), .pc_src_i(pcSrc), .func3_i(func3),
    .rs1_val_i(rs1Val), .rs2_val_i(rs2Val), .imm_i(imm),
    .link_addr_o(linkAddrH), .redirect_o(redirectH), .taken_o(takenH),
    .trap_o(trapH), .trap_pc_o(trapPcH), .halted_o(haltedH),
    .fetch_cnt_o(fetchCntH), .redir_cnt_o(redirCntH)
  );

  // Architectural branch condition for the current operands.
  function automatic bit modelCond();
    case (func3)
      3'd0:    return rs1Val == rs2Val;
      3'd1:    return rs1Val != rs2Val;
      3'd4:    return $signed(rs1Val) <  $signed(rs2Val);
      3'd5:    return $signed(rs1Val) >= $signed(rs2Val);
      3'd6:    return rs1Val <  rs2Val;
      3'd7:    return rs1Val >= rs2Val;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit modelTaken();
    return (pcSrc == 2'd3) && modelCond();
  endfunction

  function automatic logic [31:0] modelTarget();
    if (pcSrc == 2'd2) return (rs1Val + imm) & 32'hFFFF_FFFE;
    return execPc + imm;
  endfunction

  function automatic bit modelRedirect();
    return mRun && execValid && (pcSrc == 2'd1 || pcSrc == 2'd2 || modelTaken());
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic step();
    bit          red, mis, acc;
    logic [31:0] tgt;
    red = modelRedirect();
    tgt = modelTarget();
    mis = red && (tgt % 4 != 0);
    acc = mRun && fetchReady;
    @(posedge clk);
    if (rst) begin
      mRun = 0; mPc = 32'h0; mTrap = 0; mTrapPc = 32'h0;
      mFetchCnt = 32'h0; mRedirCnt = 32'h0;
    end else if (!mRun) begin
      mRun = 1; mTrap = 0;
    end else begin
      mFetchCnt = mFetchCnt + 32'(acc);
      mRedirCnt = mRedirCnt + 32'(red);
      mTrap = mis;
      if (mis) mTrapPc = execPc;
      if (mis)      mPc = 32'h100;
      else if (red) mPc = tgt;
      else if (acc) mPc = mPc + 32'd4;
    end
    #1;
  endtask

  task automatic idleInputs();
    execValid = 0; execPc = 0; pcSrc = 0; func3 = 0;
    rs1Val = 0; rs2Val = 0; imm = 0;
  endtask

  task automatic test_reset();
    rst = 1; fetchReady = 1; idleInputs();
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", pc); end
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_valid: got %b expected 0", fetchValid); end
    checks++; if (fetchCnt !== 32'h0 || redirCnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_counters: got %h/%h expected 0/0", fetchCnt, redirCnt); end
    checks++; if (trap !== 1'b0 || trapPc !== 32'h0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_trap: got trap=%b trap_pc=%h halted=%b expected 0", trap, trapPc, halted); end
    rst = 0;
    #1;
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL boot_fetch_valid: got %b expected 0", fetchValid); end
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc !== 32'(i * 4) || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL seq_pc: got pc=%h valid=%b expected %h/1", pc, fetchValid, 32'(i * 4)); end
      step();
    end
    checks++; if (fetchCnt !== 32'd4) begin errors++; $display("[TB] FAIL seq_fetch_cnt: got %0d expected 4", fetchCnt); end
  endtask

  task automatic test_branch_beq();
    logic [31:0] prevRedir;
    prevRedir = mRedirCnt;
    execValid = 1; pcSrc = 2'd3; func3 = 3'd0; rs1Val = 5; rs2Val = 5;
    execPc = 32'h20; imm = 32'h10;
    #1;
    checks++; if (redirect !== 1'b1 || taken !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken: got redirect=%b taken=%b expected 1/1", redirect, taken); end
    checks++; if (linkAddr !== 32'h24) begin errors++; $display("[TB] FAIL link_addr: got %h expected 24", linkAddr); end
    step();
    checks++; if (pc !== 32'h30) begin errors++; $display("[TB] FAIL beq_pc: got %h expected 30", pc); end
    checks++; if (redirCnt !== prevRedir + 32'd1 || redirCnt !== mRedirCnt) begin errors++; $display("[TB] FAIL beq_redir_cnt: got %0d expected %0d", redirCnt, prevRedir + 1); end
  endtask

  task automatic test_signed_compare();
    execValid = 1; pcSrc = 2'd3; func3 = 3'd4; rs1Val = 32'hFFFF_FFFF; rs2Val = 1;
    execPc = 32'h30; imm = 32'h8;
    #1;
    checks++; if (taken !== 1'b1 || redirect !== 1'b1) begin errors++; $display("[TB] FAIL blt_taken: got taken=%b redirect=%b expected 1/1", taken, redirect); end
    step();
    checks++; if (pc !== 32'h38) begin errors++; $display("[TB] FAIL blt_pc: got %h expected 38", pc); end
    func3 = 3'd6;
    #1;
    checks++; if (taken !== 1'b0 || redirect !== 1'b0) begin errors++; $display("[TB] FAIL bltu_not_taken: got taken=%b redirect=%b expected 0/0", taken, redirect); end
    step();
    checks++; if (pc !== 32'h3C) begin errors++; $display("[TB] FAIL bltu_pc_seq: got %h expected 3c", pc); end
    idleInputs();
  endtask

  task automatic test_misalign();
    logic [31:0] heldPc;
    rst = 1; step(); rst = 0; step();
    heldPc = pcH;
    execValid = 1; pcSrc = 2'd2; rs1Val = 32'h103; imm = 0; execPc = 32'h50;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("[TB] FAIL jalr_redirect: got %b expected 1", redirect); end
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("[TB] FAIL trap_pc_vector: got %h expected 100", pc); end
    checks++; if (trap !== 1'b1 || trapPc !== 32'h50) begin errors++; $display("[TB] FAIL trap_pulse: got trap=%b trap_pc=%h expected 1/50", trap, trapPc); end
    checks++; if (haltedH !== 1'b1 || fetchValidH !== 1'b0 || pcH !== heldPc) begin errors++; $display("[TB] FAIL halt_enter: got halted=%b valid=%b pc=%h expected 1/0/%h", haltedH, fetchValidH, pcH, heldPc); end
    idleInputs();
    step();
    checks++; if (trap !== 1'b0 || trapPc !== 32'h50) begin errors++; $display("[TB] FAIL trap_one_cycle: got trap=%b trap_pc=%h expected 0/50", trap, trapPc); end
    checks++; if (haltedH !== 1'b1 || fetchValidH !== 1'b0) begin errors++; $display("[TB] FAIL halt_stays: got halted=%b valid=%b expected 1/0", haltedH, fetchValidH); end
    rst = 1; step(); rst = 0; step();
    checks++; if (haltedH !== 1'b0 || fetchValidH !== 1'b1 || pcH !== 32'h0) begin errors++; $display("[TB] FAIL halt_exit_rst: got halted=%b valid=%b pc=%h expected 0/1/0", haltedH, fetchValidH, pcH); end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] heldPc;
    logic [31:0] heldCnt;
    heldPc = pc;
    heldCnt = fetchCnt;
    fetchReady = 0; idleInputs();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== heldPc || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold: got pc=%h valid=%b expected %h/1", pc, fetchValid, heldPc); end
    end
    execValid = 1; pcSrc = 2'd1; execPc = 32'h40; imm = 32'hFFFF_FFF8;
    step();
    checks++; if (pc !== 32'h38) begin errors++; $display("[TB] FAIL stall_jal_pc: got %h expected 38", pc); end
    checks++; if (fetchCnt !== heldCnt) begin errors++; $display("[TB] FAIL stall_fetch_cnt: got %0d expected %0d", fetchCnt, heldCnt); end
    idleInputs(); fetchReady = 1;
  endtask

  task automatic test_rst_redirect();
    fetchReady = 1; step(); step();
    execValid = 1; pcSrc = 2'd1; execPc = 32'h40; imm = 32'h2; rst = 1;
    step();
    checks++; if (pc !== 32'h0 || fetchCnt !== 32'h0 || redirCnt !== 32'h0) begin errors++; $display("[TB] FAIL rst_redirect_state: got pc=%h cnt=%0d/%0d expected 0/0/0", pc, fetchCnt, redirCnt); end
    checks++; if (trap !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect_trap: got %b expected 0", trap); end
    rst = 0; idleInputs();
    step();
    checks++; if (trap !== 1'b0 || pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_after_trap: got trap=%b pc=%h expected 0/0", trap, pc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      fetchReady = ($urandom_range(0, 3) != 0);
      execValid  = $urandom_range(0, 1);
      pcSrc      = 2'($urandom_range(0, 3));
      func3      = 3'($urandom_range(0, 7));
      execPc     = $urandom & 32'hFFFF_FFFC;
      rs2Val     = $urandom;
      rs1Val     = $urandom_range(0, 1) ? rs2Val : $urandom;
      if ($urandom_range(0, 1) == 0) rs1Val = rs1Val ^ 32'h8000_0000;
      if ($urandom_range(0, 7) != 0 && pcSrc == 2'd2) rs1Val = rs1Val & 32'hFFFF_FFFC;
      imm        = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'h2;
      #1;
      checks++; if (redirect !== (!rst && modelRedirect()) && !rst) begin errors++; $display("[TB] FAIL rnd_redirect: got %b expected %b", redirect, modelRedirect()); end
      checks++; if (taken !== modelTaken()) begin errors++; $display("[TB] FAIL rnd_taken: got %b expected %b", taken, modelTaken()); end
      checks++; if (linkAddr !== execPc + 32'd4) begin errors++; $display("[TB] FAIL rnd_link: got %h expected %h", linkAddr, execPc + 32'd4); end
      checks++; if (fetchValid !== mRun) begin errors++; $display("[TB] FAIL rnd_fetch_valid: got %b expected %b", fetchValid, mRun); end
      step();
      checks++; if (pc !== mPc) begin errors++; $display("[TB] FAIL rnd_pc: got %h expected %h", pc, mPc); end
      checks++; if (trap !== mTrap || trapPc !== mTrapPc) begin errors++; $display("[TB] FAIL rnd_trap: got %b/%h expected %b/%h", trap, trapPc, mTrap, mTrapPc); end
      checks++; if (fetchCnt !== mFetchCnt || redirCnt !== mRedirCnt) begin errors++; $display("[TB] FAIL rnd_counters: got %0d/%0d expected %0d/%0d", fetchCnt, redirCnt, mFetchCnt, mRedirCnt); end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; fetchReady = 0; idleInputs();
    mRun = 0; mPc = 0; mTrap = 0; mTrapPc = 0; mFetchCnt = 0; mRedirCnt = 0;
    test_reset();
    test_branch_beq();
    test_signed_compare();
    test_misalign();
    test_stall_redirect();
    test_rst_redirect();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
